exec_cdb_unit: RTL and testbench
================================

Name: exec_cdb_unit

Overview:
- Execute stage directly downstream of the reservation stations: accepts one dispatched operation per cycle (operands already read from the register bank) and runs it in an add/branch unit or an iterative mul/div unit.
- Releases the originating RS entry on acceptance.
- Broadcasts each result on a single common data bus (CDB) to the ROB and the RS wakeup logic.
- Exposes per-unit busy flags that gate further dispatch.

Parameters:
- DATA_W, 8, operand/result width
- ADD_LAT, 1, add/sub/branch cycles (>=1)
- MUL_LAT, 3, multiply cycles (>=1)
- DIV_LAT, 6, divide cycles (>=1)

Ports:
- clk1  in  1  single clock, all state on posedge
- rst  in  1  synchronous reset, active-high
- flush  in  1  synchronous kill of all in-flight ops (mispredict)
- iss_valid  in  1  dispatch request from RS
- iss_ready  out  1  target unit can accept this cycle (combinational)
- iss_func  in  4  0000 add, 0001 sub, 0010 mul, 0011 div, 0110 beq, 0111 bne
- iss_rsindex  in  2  originating RS slot
- iss_rs1data  in  DATA_W  operand A
- iss_rs2data  in  DATA_W  operand B
- iss_rob_ind  in  3  destination ROB entry
- iss_rd  in  4  architectural destination
- rs_free_valid  out  1  one-cycle pulse: RS slot released
- rs_free_unit  out  1  0=add array, 1=mul array
- rs_free_index  out  2  slot released
- add_busy  out  1  add unit not IDLE
- mul_busy  out  1  mul unit not IDLE
- cdb_valid  out  1  broadcast valid
- cdb_rob_ind  out  3  ROB tag of result
- cdb_rd  out  4  destination register
- cdb_data  out  DATA_W  result
- cdb_exc  out  1  divide-by-zero flag

Behaviour:
- Reset: all outputs 0 and both units IDLE. Reset overrides flush and iss_valid.
- Unit select:
  - func 0000/0001/0110/0111 go to the add unit.
  - func 0010/0011 go to the mul unit.
  - Any other func: iss_ready=0; never accepted.
- iss_ready = selected unit IDLE and flush=0.
- Accept = iss_valid & iss_ready at a posedge.
  - The unit latches operands, func, rob_ind and rd.
  - The unit loads its down-counter with its latency and enters EXEC.
  - In the next cycle: rs_free_valid=1 with unit and index, held exactly one cycle.
- Unit FSM (each unit independent): IDLE -> EXEC -> DONE -> IDLE.
  - EXEC: counter decrements each cycle; at 1 the result is written to the unit result register and the unit goes to DONE.
  - Accept at edge N gives DONE after edge N+LAT.
  - DONE: the unit waits for a CDB grant. On grant it returns to IDLE and can accept again the same cycle it is granted.
- CDB arbitration:
  - One broadcast per cycle, registered.
  - If both units are DONE, the mul unit wins; the add unit holds DONE (add_busy stays 1).
  - Granted unit: cdb_valid=1 with its tag, rd, data and exc in the cycle after the grant edge, for exactly one cycle unless the next grant is back-to-back.
  - Minimum accept-to-cdb_valid latency: ADD_LAT+1 cycles.
- Arithmetic:
  - All results are modulo 2^DATA_W, unsigned.
  - add = A+B; sub = A-B (wraps).
  - mul = low DATA_W bits of A*B.
  - div = floor(A/B).
  - B=0 on div: data = all ones, cdb_exc=1. cdb_exc=0 for every other op.
  - beq: data = (A==B) zero-extended; bne: data = (A!=B) zero-extended.
- Flush:
  - Both units go to IDLE; cdb_valid=0 next cycle.
  - Any acceptance in the flush cycle is blocked.
  - rs_free_valid is unaffected if already scheduled.
- The RS must not re-dispatch a slot until its rs_free pulse; the unit does not check for this.

Test Plan:
- Add: rst, then accept add A=8'h05 B=8'h03 rob=2 rd=4 rsindex=1 -> rs_free (unit0, idx1) next cycle; cdb_valid=1 with data 8'h08, rob 2, rd 4 exactly 2 cycles after accept; add_busy low afterwards.
- Sub wrap and bne: sub 8'h02-8'h05 -> cdb_data 8'hFD. bne 7,7 -> 0. beq 7,7 -> 1.
- Mul/div: mul 8'h10*8'h11 -> 8'h10 after 4 cycles. div 8'd100/8'd7 -> 8'd14 after 7 cycles, cdb_exc=0. div by 0 -> 8'hFF with cdb_exc=1.
- Contention: accept mul at edge 0 and add at edge 2 (both DONE at edge 3) -> mul broadcast first, add one cycle later; add_busy stays high one extra cycle.
- Backpressure: while mul is in EXEC, present a second mul -> iss_ready=0 and no rs_free pulse. Present an add at the same time -> accepted.
- Flush/reset mid-op: flush during div EXEC -> no CDB broadcast, mul_busy=0 next cycle. rst asserted together with iss_valid -> nothing accepted, all outputs 0.

Source files
------------

// File: rtl/exec_cdb_if.sv
// Issue / release / CDB bundle between the RS, the execute stage and the ROB.
// The master side is the dispatch logic; the slave side is exec_cdb_unit.
interface exec_cdb_if #(
  parameter int DATA_W = 8
);
  logic              iss_valid;
  logic              iss_ready;
  logic [3:0]        iss_func;
  logic [1:0]        iss_rsindex;
  logic [DATA_W-1:0] iss_rs1data;
  logic [DATA_W-1:0] iss_rs2data;
  logic [2:0]        iss_rob_ind;
  logic [3:0]        iss_rd;
  logic              rs_free_valid;
  logic              rs_free_unit;
  logic [1:0]        rs_free_index;
  logic              add_busy;
  logic              mul_busy;
  logic              cdb_valid;
  logic [2:0]        cdb_rob_ind;
  logic [3:0]        cdb_rd;
  logic [DATA_W-1:0] cdb_data;
  logic              cdb_exc;

  modport master (
    output iss_valid, iss_func, iss_rsindex,
    output iss_rs1data, iss_rs2data,
    output iss_rob_ind, iss_rd,
    input  iss_ready,
    input  rs_free_valid, rs_free_unit, rs_free_index,
    input  add_busy, mul_busy,
    input  cdb_valid, cdb_rob_ind, cdb_rd,
    input  cdb_data, cdb_exc
  );

  modport slave (
    input  iss_valid, iss_func, iss_rsindex,
    input  iss_rs1data, iss_rs2data,
    input  iss_rob_ind, iss_rd,
    output iss_ready,
    output rs_free_valid, rs_free_unit, rs_free_index,
    output add_busy, mul_busy,
    output cdb_valid, cdb_rob_ind, cdb_rd,
    output cdb_data, cdb_exc
  );
endinterface

// File: rtl/exec_cdb_unit.sv
// Execute stage: add/branch unit and iterative mul/div unit sharing one CDB.
// Each unit is IDLE -> EXEC -> DONE -> IDLE; mul wins the CDB on a tie.
module exec_cdb_unit #(
  parameter int DATA_W  = 8,
  parameter int ADD_LAT = 1,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 6
) (
  input logic       clk1,
  input logic       rst,
  input logic       flush,
  exec_cdb_if.slave io
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } st_t;

  typedef logic [DATA_W-1:0] word_t;

  localparam int ML1 = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
  localparam int MAXL = (DIV_LAT > ML1) ? DIV_LAT : ML1;
  localparam int CW = $clog2(MAXL + 1);

  st_t           a_st, m_st;
  logic [CW-1:0] a_cnt, m_cnt;
  logic          a_cmp, a_inv;
  logic          m_div, m_exc;
  word_t         a_op1, a_op2, a_res, a_res_n;
  word_t         m_op1, m_op2, m_res, m_res_n;
  logic          m_exc_n;
  logic [2:0]    a_rob, m_rob;
  logic [3:0]    a_rd, m_rd;

  logic is_add, is_mul;
  logic g_add, g_mul;
  logic add_rdy, mul_rdy;
  logic acc_add, acc_mul;

  logic          cdb_valid, cdb_exc;
  logic [2:0]    cdb_rob;
  logic [3:0]    cdb_rd;
  word_t         cdb_data;
  logic          rsf_valid, rsf_unit;
  logic [1:0]    rsf_index;

  always_comb begin
    is_add = 1'b0;
    is_mul = 1'b0;
    case (io.iss_func)
      4'b0000, 4'b0001,
      4'b0110, 4'b0111: is_add = 1'b1;
      4'b0010, 4'b0011: is_mul = 1'b1;
      default: ;
    endcase
  end

  // A unit granted this cycle frees up at the same edge
  assign g_mul = (m_st == DONE) && !flush;
  assign g_add = (a_st == DONE) && !flush && !g_mul;

  assign add_rdy = !rst && !flush
                 && ((a_st == IDLE) || g_add);
  assign mul_rdy = !rst && !flush
                 && ((m_st == IDLE) || g_mul);

  assign io.iss_ready = (is_add && add_rdy)
                     || (is_mul && mul_rdy);
  assign acc_add = io.iss_valid && is_add && add_rdy;
  assign acc_mul = io.iss_valid && is_mul && mul_rdy;

  always_comb begin
    a_res_n = a_op1 + a_op2;
    if (a_cmp) begin
      a_res_n = '0;
      a_res_n[0] = (a_op1 == a_op2) ^ a_inv;
    end else if (a_inv) begin
      a_res_n = a_op1 - a_op2;
    end
  end

  always_comb begin
    m_res_n = m_op1 * m_op2;
    m_exc_n = 1'b0;
    if (m_div) begin
      if (m_op2 == '0) begin
        m_res_n = '1;
        m_exc_n = 1'b1;
      end else begin
        m_res_n = m_op1 / m_op2;
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      a_st  <= IDLE;
      a_cnt <= '0;
      a_cmp <= 1'b0;
      a_inv <= 1'b0;
      a_op1 <= '0;
      a_op2 <= '0;
      a_res <= '0;
      a_rob <= '0;
      a_rd  <= '0;
    end else if (flush) begin
      a_st <= IDLE;
    end else if (acc_add) begin
      a_st  <= EXEC;
      a_cnt <= CW'(ADD_LAT);
      a_cmp <= io.iss_func[2];
      a_inv <= io.iss_func[0];
      a_op1 <= io.iss_rs1data;
      a_op2 <= io.iss_rs2data;
      a_rob <= io.iss_rob_ind;
      a_rd  <= io.iss_rd;
    end else begin
      unique case (a_st)
        EXEC: begin
          if (a_cnt == CW'(1)) begin
            a_res <= a_res_n;
            a_st  <= DONE;
          end else begin
            a_cnt <= a_cnt - CW'(1);
          end
        end
        DONE: if (g_add) a_st <= IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      m_st  <= IDLE;
      m_cnt <= '0;
      m_div <= 1'b0;
      m_exc <= 1'b0;
      m_op1 <= '0;
      m_op2 <= '0;
      m_res <= '0;
      m_rob <= '0;
      m_rd  <= '0;
    end else if (flush) begin
      m_st <= IDLE;
    end else if (acc_mul) begin
      m_st  <= EXEC;
      m_cnt <= io.iss_func[0] ? CW'(DIV_LAT)
                              : CW'(MUL_LAT);
      m_div <= io.iss_func[0];
      m_op1 <= io.iss_rs1data;
      m_op2 <= io.iss_rs2data;
      m_rob <= io.iss_rob_ind;
      m_rd  <= io.iss_rd;
    end else begin
      unique case (m_st)
        EXEC: begin
          if (m_cnt == CW'(1)) begin
            m_res <= m_res_n;
            m_exc <= m_exc_n;
            m_st  <= DONE;
          end else begin
            m_cnt <= m_cnt - CW'(1);
          end
        end
        DONE: if (g_mul) m_st <= IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      cdb_valid <= 1'b0;
      cdb_rob   <= '0;
      cdb_rd    <= '0;
      cdb_data  <= '0;
      cdb_exc   <= 1'b0;
    end else begin
      cdb_valid <= g_mul || g_add;
      unique case (1'b1)
        g_mul: begin
          cdb_rob  <= m_rob;
          cdb_rd   <= m_rd;
          cdb_data <= m_res;
          cdb_exc  <= m_exc;
        end
        g_add: begin
          cdb_rob  <= a_rob;
          cdb_rd   <= a_rd;
          cdb_data <= a_res;
          cdb_exc  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      rsf_valid <= 1'b0;
      rsf_unit  <= 1'b0;
      rsf_index <= '0;
    end else begin
      rsf_valid <= acc_add || acc_mul;
      if (acc_add || acc_mul) begin
        rsf_unit  <= acc_mul;
        rsf_index <= io.iss_rsindex;
      end
    end
  end

  assign io.rs_free_valid = rsf_valid;
  assign io.rs_free_unit  = rsf_unit;
  assign io.rs_free_index = rsf_index;
  assign io.add_busy      = (a_st != IDLE);
  assign io.mul_busy      = (m_st != IDLE);
  assign io.cdb_valid     = cdb_valid;
  assign io.cdb_rob_ind   = cdb_rob;
  assign io.cdb_rd        = cdb_rd;
  assign io.cdb_data      = cdb_data;
  assign io.cdb_exc       = cdb_exc;

endmodule

// File: tb/tb_exec_cdb_unit.sv
// Bench for exec_cdb_unit: directed scenarios plus random traffic
// checked every cycle against a timestamp-based transaction model.
module tb_exec_cdb_unit;
  localparam int DW = 8;
  localparam int AL = 1;
  localparam int ML = 3;
  localparam int DL = 6;

  logic clk1 = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  exec_cdb_if #(.DATA_W(DW)) bus ();

  exec_cdb_unit #(
    .DATA_W(DW), .ADD_LAT(AL), .MUL_LAT(ML), .DIV_LAT(DL)
  ) dut (
    .clk1(clk1),
    .rst(rst),
    .flush(flush),
    .io(bus)
  );

  always #5 clk1 = ~clk1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit started = 1'b0;

  task automatic chk(string n, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               n, got, exp, cyc);
    end
  endtask

  // ---- transaction model: one pending op per unit, tagged with
  // the edge at which it was accepted plus its latency
  bit         occ_a, occ_m;
  int         rdy_a, rdy_m;
  logic [7:0] r_a, r_m;
  bit         e_m;
  logic [2:0] rob_a, rob_m;
  logic [3:0] rd_a, rd_m;

  bit         x_cv, x_e, x_fv, x_fu, x_ab, x_mb;
  logic [2:0] x_rob;
  logic [3:0] x_rd;
  logic [7:0] x_d;
  logic [1:0] x_fi;

  function automatic int cls(logic [3:0] f);
    if (f == 4'd0 || f == 4'd1 || f == 4'd6 || f == 4'd7)
      return 1;
    if (f == 4'd2 || f == 4'd3) return 2;
    return 0;
  endfunction

  function automatic logic [8:0] calc(logic [3:0] f,
                                      logic [7:0] a,
                                      logic [7:0] b);
    logic [7:0] d;
    logic e;
    e = 1'b0;
    case (f)
      4'd0: d = a + b;
      4'd1: d = a - b;
      4'd2: d = a * b;
      4'd3: begin
        if (b == 8'd0) begin
          d = 8'hFF;
          e = 1'b1;
        end else begin
          d = a / b;
        end
      end
      4'd6: d = (a == b) ? 8'd1 : 8'd0;
      default: d = (a != b) ? 8'd1 : 8'd0;
    endcase
    return {e, d};
  endfunction

  function automatic bit done_a(int t);
    return occ_a && (t > rdy_a);
  endfunction

  function automatic bit done_m(int t);
    return occ_m && (t > rdy_m);
  endfunction

  function automatic bit pred_ready(int t);
    bit md, ad;
    if (rst || flush) return 1'b0;
    md = done_m(t);
    ad = done_a(t) && !md;
    case (cls(bus.iss_func))
      1: return !occ_a || ad;
      2: return !occ_m || md;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk1) begin : model
    int t;
    bit gm, ga, acc;
    int c;
    logic [8:0] r;
    t = cyc;
    if (rst) begin
      occ_a = 0; occ_m = 0;
      x_cv = 0; x_e = 0; x_fv = 0; x_fu = 0;
      x_rob = '0; x_rd = '0; x_d = '0; x_fi = '0;
    end else begin
      gm = !flush && done_m(t);
      ga = !flush && done_a(t) && !done_m(t);
      c = cls(bus.iss_func);
      acc = bus.iss_valid && pred_ready(t);
      x_cv = gm || ga;
      if (gm) begin
        x_rob = rob_m; x_rd = rd_m; x_d = r_m; x_e = e_m;
      end else if (ga) begin
        x_rob = rob_a; x_rd = rd_a; x_d = r_a; x_e = 1'b0;
      end
      x_fv = acc;
      if (acc) begin
        x_fu = (c == 2);
        x_fi = bus.iss_rsindex;
      end
      if (flush) begin
        occ_a = 0; occ_m = 0;
      end else begin
        if (ga) occ_a = 0;
        if (gm) occ_m = 0;
        if (acc) begin
          r = calc(bus.iss_func, bus.iss_rs1data,
                   bus.iss_rs2data);
          if (c == 1) begin
            occ_a = 1; rdy_a = t + AL; r_a = r[7:0];
            rob_a = bus.iss_rob_ind; rd_a = bus.iss_rd;
          end else begin
            occ_m = 1;
            rdy_m = t + (bus.iss_func[0] ? DL : ML);
            r_m = r[7:0]; e_m = r[8];
            rob_m = bus.iss_rob_ind; rd_m = bus.iss_rd;
          end
        end
      end
    end
    x_ab = occ_a;
    x_mb = occ_m;
    cyc++;
  end

  always @(negedge clk1) begin
    if (started) begin
      chk("iss_ready", bus.iss_ready, pred_ready(cyc));
      chk("cdb_valid", bus.cdb_valid, x_cv);
      if (x_cv) begin
        chk("cdb_rob", bus.cdb_rob_ind, x_rob);
        chk("cdb_rd", bus.cdb_rd, x_rd);
        chk("cdb_data", bus.cdb_data, x_d);
        chk("cdb_exc", bus.cdb_exc, x_e);
      end
      chk("rs_free_valid", bus.rs_free_valid, x_fv);
      if (x_fv) begin
        chk("rs_free_unit", bus.rs_free_unit, x_fu);
        chk("rs_free_index", bus.rs_free_index, x_fi);
      end
      chk("add_busy", bus.add_busy, x_ab);
      chk("mul_busy", bus.mul_busy, x_mb);
    end
  end

  // ---- stimulus helpers (drive #1 after posedge)
  task automatic drive(logic [3:0] f, logic [7:0] a,
                       logic [7:0] b, logic [2:0] rob,
                       logic [3:0] rd, logic [1:0] idx);
    bus.iss_valid = 1'b1;
    bus.iss_func = f;
    bus.iss_rs1data = a;
    bus.iss_rs2data = b;
    bus.iss_rob_ind = rob;
    bus.iss_rd = rd;
    bus.iss_rsindex = idx;
  endtask

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus.add_busy || bus.mul_busy || bus.cdb_valid)
           && n < 60) begin
      @(negedge clk1);
      n++;
    end
    chk("idle_wait", (n < 60), 1);
  endtask

  task automatic run_op(string n, logic [3:0] f,
                        logic [7:0] a, logic [7:0] b,
                        logic [2:0] rob, logic [3:0] rd,
                        logic [7:0] ed, logic ee, int elat);
    int k;
    wait_idle();
    step();
    drive(f, a, b, rob, rd, 2'd1);
    @(negedge clk1);
    chk({n, "_ready"}, bus.iss_ready, 1);
    step();
    bus.iss_valid = 1'b0;
    @(negedge clk1);
    k = 1;
    chk({n, "_free"}, bus.rs_free_valid, 1);
    chk({n, "_free_unit"}, bus.rs_free_unit, (cls(f) == 2));
    chk({n, "_free_idx"}, bus.rs_free_index, 1);
    while (!bus.cdb_valid && k < 20) begin
      @(negedge clk1);
      k++;
    end
    chk({n, "_lat"}, k - 1, elat);
    chk({n, "_data"}, bus.cdb_data, ed);
    chk({n, "_exc"}, bus.cdb_exc, ee);
    chk({n, "_rob"}, bus.cdb_rob_ind, rob);
    chk({n, "_rd"}, bus.cdb_rd, rd);
    @(negedge clk1);
    chk({n, "_busy_after"}, bus.add_busy | bus.mul_busy, 0);
  endtask

  initial begin
    int cnt;
    int fsel;
    logic [3:0] ftab [8];
    ftab[0] = 4'd0; ftab[1] = 4'd1; ftab[2] = 4'd2;
    ftab[3] = 4'd3; ftab[4] = 4'd6; ftab[5] = 4'd7;
    ftab[6] = 4'd4; ftab[7] = 4'd15;

    bus.iss_valid = 1'b0;
    bus.iss_func = 4'd0;
    bus.iss_rs1data = '0;
    bus.iss_rs2data = '0;
    bus.iss_rob_ind = '0;
    bus.iss_rd = '0;
    bus.iss_rsindex = '0;

    repeat (2) @(posedge clk1);
    started = 1'b1;
    @(negedge clk1);
    chk("rst_cdb_valid", bus.cdb_valid, 0);
    chk("rst_cdb_data", bus.cdb_data, 0);
    chk("rst_busy", {bus.add_busy, bus.mul_busy}, 0);
    chk("rst_free", bus.rs_free_valid, 0);
    step();
    rst = 1'b0;

    run_op("add", 4'd0, 8'h05, 8'h03, 3'd2, 4'd4, 8'h08, 0, 2);
    run_op("sub", 4'd1, 8'h02, 8'h05, 3'd3, 4'd5, 8'hFD, 0, 2);
    run_op("bne", 4'd7, 8'd7, 8'd7, 3'd4, 4'd6, 8'h00, 0, 2);
    run_op("beq", 4'd6, 8'd7, 8'd7, 3'd5, 4'd7, 8'h01, 0, 2);
    run_op("mul", 4'd2, 8'h10, 8'h11, 3'd6, 4'd8, 8'h10, 0, 4);
    run_op("div", 4'd3, 8'd100, 8'd7, 3'd7, 4'd9, 8'd14, 0, 7);
    run_op("div0", 4'd3, 8'd9, 8'd0, 3'd1, 4'd2, 8'hFF, 1, 7);

    // contention: mul accepted edge 0, add edge 2
    wait_idle();
    step(); drive(4'd2, 8'd3, 8'd4, 3'd5, 4'd1, 2'd0);
    step(); bus.iss_valid = 1'b0;
    step(); drive(4'd0, 8'd1, 8'd2, 3'd6, 4'd2, 2'd2);
    step(); bus.iss_valid = 1'b0;
    @(negedge clk1);
    @(negedge clk1);
    chk("cont_add_busy3", bus.add_busy, 1);
    @(negedge clk1);
    chk("cont_first_valid", bus.cdb_valid, 1);
    chk("cont_first_rob", bus.cdb_rob_ind, 5);
    chk("cont_first_data", bus.cdb_data, 12);
    chk("cont_add_busy4", bus.add_busy, 1);
    @(negedge clk1);
    chk("cont_second_valid", bus.cdb_valid, 1);
    chk("cont_second_rob", bus.cdb_rob_ind, 6);
    chk("cont_second_data", bus.cdb_data, 3);
    chk("cont_add_busy5", bus.add_busy, 0);

    // backpressure on the mul unit, add still accepted
    wait_idle();
    step(); drive(4'd2, 8'd2, 8'd3, 3'd1, 4'd1, 2'd0);
    step(); drive(4'd2, 8'd4, 8'd5, 3'd2, 4'd2, 2'd3);
    @(negedge clk1);
    chk("bp_mul_ready", bus.iss_ready, 0);
    step(); drive(4'd0, 8'd1, 8'd1, 3'd3, 4'd3, 2'd2);
    @(negedge clk1);
    chk("bp_no_free", bus.rs_free_valid, 0);
    chk("bp_add_ready", bus.iss_ready, 1);
    step(); bus.iss_valid = 1'b0;
    @(negedge clk1);
    chk("bp_add_free", bus.rs_free_valid, 1);
    chk("bp_add_unit", bus.rs_free_unit, 0);
    chk("bp_add_idx", bus.rs_free_index, 2);

    // flush while div is executing
    wait_idle();
    step(); drive(4'd3, 8'd100, 8'd7, 3'd4, 4'd4, 2'd1);
    step(); bus.iss_valid = 1'b0;
    step(); flush = 1'b1;
    drive(4'd0, 8'd1, 8'd1, 3'd5, 4'd5, 2'd0);
    @(negedge clk1);
    chk("flush_ready", bus.iss_ready, 0);
    step(); flush = 1'b0; bus.iss_valid = 1'b0;
    @(negedge clk1);
    chk("flush_mul_busy", bus.mul_busy, 0);
    chk("flush_no_free", bus.rs_free_valid, 0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk1);
      if (bus.cdb_valid) cnt++;
    end
    chk("flush_no_cdb", cnt, 0);

    // reset together with a dispatch
    wait_idle();
    step(); drive(4'd2, 8'd3, 8'd3, 3'd1, 4'd1, 2'd0);
    step(); rst = 1'b1;
    drive(4'd0, 8'd1, 8'd2, 3'd2, 4'd2, 2'd1);
    @(negedge clk1);
    chk("rst_iss_ready", bus.iss_ready, 0);
    step();
    @(negedge clk1);
    chk("rst2_free", bus.rs_free_valid, 0);
    chk("rst2_busy", {bus.add_busy, bus.mul_busy}, 0);
    chk("rst2_cdb", {bus.cdb_valid, bus.cdb_data}, 0);
    step(); rst = 1'b0; bus.iss_valid = 1'b0;

    // random traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      step();
      fsel = int'($urandom_range(0, 9));
      if (fsel > 7) fsel = fsel - 6;
      drive(ftab[fsel], 8'($urandom), 8'($urandom),
            3'($urandom), 4'($urandom), 2'($urandom));
      if ($urandom_range(0, 7) == 0) bus.iss_rs2data = 8'd0;
      if ($urandom_range(0, 7) == 0) bus.iss_rs2data = bus.iss_rs1data;
      bus.iss_valid = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 199) == 0);
    end
    step();
    rst = 1'b0; flush = 1'b0; bus.iss_valid = 1'b0;
    repeat (20) @(posedge clk1);
    @(negedge clk1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
